// File: rtl/glyph_pkg.sv
// ============================================================================
// Module   : glyph_pkg
// Brief    : Shared types, defaults and width helpers for the glyph text renderer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package glyph_pkg;

  typedef logic [23:0] rgb_t;

  localparam int   X_OFFSET_DEFAULT   = 158;
  localparam rgb_t BORDER_RGB_DEFAULT = 24'h000000;

  // Never returns 0, so single-entry dimensions still get a 1-bit field.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  localparam int DEF_CODE_W      = 8;
  localparam int DEF_GLYPH_W     = 8;
  localparam int DEF_TEXT_ADDR_W = clog2_min1(80 * 60);
  localparam int DEF_ROM_ADDR_W  = DEF_CODE_W + clog2_min1(8);

endpackage

`default_nettype wire

// File: rtl/glyph_text_renderer_if.sv
// ============================================================================
// Module   : glyph_text_renderer_if
// Brief    : Text-buffer and glyph-ROM read ports of the renderer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface glyph_text_renderer_if
  import glyph_pkg::*;
#(
  parameter int TEXT_ADDR_W = DEF_TEXT_ADDR_W,
  parameter int CODE_W      = DEF_CODE_W,
  parameter int ROM_ADDR_W  = DEF_ROM_ADDR_W,
  parameter int GLYPH_W     = DEF_GLYPH_W
);

  logic [TEXT_ADDR_W-1:0] text_addr;
  logic [CODE_W-1:0]      text_data;
  logic [ROM_ADDR_W-1:0]  rom_addr;
  logic [GLYPH_W-1:0]     rom_data;

  modport master (
    output text_addr,
    output rom_addr,
    input  text_data,
    input  rom_data
  );

  modport slave (
    input  text_addr,
    input  rom_addr,
    output text_data,
    output rom_data
  );

endinterface

`default_nettype wire

// File: rtl/glyph_pipe_delay.sv
// ============================================================================
// Module   : glyph_pipe_delay
// Brief    : WIDTH x DEPTH shift register with synchronous active-high reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module glyph_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/glyph_text_renderer.sv
// ============================================================================
// Module   : glyph_text_renderer
// Brief    : 3-cycle character-cell text renderer; GLYPH_TEXT_CURSOR_EN adds a
//            blinking inverse-video cursor cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module glyph_text_renderer
  import glyph_pkg::*;
#(
  parameter int   GLYPH_W      = 8,
  parameter int   GLYPH_H      = 8,
  parameter int   COLS         = 80,
  parameter int   ROWS         = 60,
  parameter int   CODE_W       = 8,
  parameter int   X_OFFSET     = X_OFFSET_DEFAULT,
  parameter rgb_t BORDER_RGB   = BORDER_RGB_DEFAULT,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright_in,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  rgb_t        fg_rgb,
  input  rgb_t        bg_rgb,
  glyph_text_renderer_if.master mem,
`ifdef GLYPH_TEXT_CURSOR_EN
  input  logic [clog2_min1(COLS)-1:0] cursor_col,
  input  logic [clog2_min1(ROWS)-1:0] cursor_row,
`endif
  output rgb_t        rgb_out,
  output logic        bright_out
);

  localparam int GX_W  = clog2_min1(GLYPH_W);
  localparam int GY_W  = clog2_min1(GLYPH_H);
  localparam int GX_SH = $clog2(GLYPH_W);
  localparam int GY_SH = $clog2(GLYPH_H);
  localparam int COL_W = clog2_min1(COLS);
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int TA_W  = clog2_min1(COLS * ROWS);
  localparam int unsigned AREA_W_PX = COLS * GLYPH_W;
  localparam int unsigned AREA_H_PX = ROWS * GLYPH_H;

  if (!is_pow2(GLYPH_W) || !is_pow2(GLYPH_H) || (COLS * GLYPH_W > 1024) ||
      (BLINK_FRAMES < 1)) begin : g_param_check
    $error("glyph_text_renderer: illegal glyph geometry or blink period");
  end

  // Stage 0: pixel position to cell coordinates
  logic [9:0]       x_pos;
  logic [9:0]       y_pos;
  logic             in_area;
  logic [GX_W-1:0]  gx;
  logic [GY_W-1:0]  gy;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_comb begin
    x_pos   = hcount - 10'(X_OFFSET);
    y_pos   = vcount;
    in_area = bright_in && ({22'd0, x_pos} < AREA_W_PX) && ({22'd0, y_pos} < AREA_H_PX);
    gx      = GX_W'(x_pos & 10'(GLYPH_W - 1));
    gy      = GY_W'(y_pos & 10'(GLYPH_H - 1));
    col     = COL_W'(x_pos >> GX_SH);
    row     = ROW_W'(y_pos >> GY_SH);
    mem.text_addr = in_area ? (TA_W'(row) * TA_W'(COLS) + TA_W'(col)) : '0;
  end

  // bright/in_area/gx travel two stages to meet rom_data
  logic            p2_bright;
  logic            p2_in_area;
  logic [GX_W-1:0] p2_gx;

  glyph_pipe_delay #(
    .WIDTH (2 + GX_W),
    .DEPTH (2)
  ) u_align (
    .clk   (clk),
    .reset (reset),
    .d     ({bright_in, in_area, gx}),
    .q     ({p2_bright, p2_in_area, p2_gx})
  );

  logic [GY_W-1:0] p1_gy_q, p1_gy_d;

  assign mem.rom_addr = {mem.text_data, p1_gy_q};

  logic cursor_hit;

`ifdef GLYPH_TEXT_CURSOR_EN
  localparam int FC_W = clog2_min1(BLINK_FRAMES);

  logic [COL_W-1:0] p1_col_q, p1_col_d;
  logic [ROW_W-1:0] p1_row_q, p1_row_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             cursor_hit_q, cursor_hit_d;

  always_comb begin
    p1_col_d      = col;
    p1_row_d      = row;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if ((hcount == 10'd0) && (vcount == 10'd0)) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end
    end
    cursor_hit_d = (p1_col_q == cursor_col) && (p1_row_q == cursor_row) && blink_phase_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_col_q      <= '0;
      p1_row_q      <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      cursor_hit_q  <= 1'b0;
    end else begin
      p1_col_q      <= p1_col_d;
      p1_row_q      <= p1_row_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      cursor_hit_q  <= cursor_hit_d;
    end
  end

  assign cursor_hit = cursor_hit_q;
`else
  assign cursor_hit = 1'b0;
`endif

  // Stage 3: colour select; the cursor inverts the glyph bit, swapping fg/bg
  rgb_t            rgb_q, rgb_d;
  logic            bright_out_q, bright_out_d;
  logic [GX_W-1:0] bit_idx;
  logic            glyph_bit;

  always_comb begin
    p1_gy_d      = gy;
    bit_idx      = GX_W'(GLYPH_W - 1) - p2_gx;
    glyph_bit    = mem.rom_data[bit_idx] ^ cursor_hit;
    bright_out_d = p2_bright;
    if (!p2_bright) begin
      rgb_d = '0;
    end else if (!p2_in_area) begin
      rgb_d = BORDER_RGB;
    end else begin
      rgb_d = glyph_bit ? fg_rgb : bg_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_gy_q      <= '0;
      rgb_q        <= '0;
      bright_out_q <= 1'b0;
    end else begin
      p1_gy_q      <= p1_gy_d;
      rgb_q        <= rgb_d;
      bright_out_q <= bright_out_d;
    end
  end

  assign rgb_out    = rgb_q;
  assign bright_out = bright_out_q;

endmodule

`default_nettype wire

// File: doc/glyph_text_renderer.md
Name: glyph_text_renderer

Overview:
- Pipelined character-cell text renderer for the VGA path.
- Maps each pixel (hcount, vcount) to a cell in a COLS x ROWS text grid, fetches the character code from an external text buffer, then fetches the glyph row from an external glyph ROM.
- Emits foreground, background or border colour with a fixed 3-cycle latency.
- Sits between the VGA timing generator and the DAC/output register; supersedes single-glyph bit generation.

Parameters:
- GLYPH_W, 8, glyph width in pixels; power of two.
- GLYPH_H, 8, glyph height in pixels; power of two.
- COLS, 80, text columns.
- ROWS, 60, text rows.
- CODE_W, 8, character code width.
- X_OFFSET, 158, hcount value of the first visible pixel.
- BORDER_RGB, 24'h000000, colour for visible pixels outside the text area.
- BLINK_FRAMES, 30, frames per cursor blink half-period (CURSOR_EN only).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- bright_in  in  1  visible-region flag from timing generator
- hcount  in  10  horizontal counter
- vcount  in  10  vertical counter
- fg_rgb  in  24  foreground colour
- bg_rgb  in  24  background colour
- text_addr  out  clog2(COLS*ROWS)  text buffer address; combinational
- text_data  in  CODE_W  character code; sync-read, valid one cycle after text_addr
- rom_addr  out  CODE_W+clog2(GLYPH_H)  glyph ROM address {code, glyph_row}; combinational
- rom_data  in  GLYPH_W  glyph row; sync-read, valid one cycle after rom_addr; MSB is the leftmost pixel
- rgb_out  out  24  registered pixel colour
- bright_out  out  1  bright_in delayed 3 cycles
- cursor_col  in  clog2(COLS)  cursor column (CURSOR_EN only)
- cursor_row  in  clog2(ROWS)  cursor row (CURSOR_EN only)

Behaviour:
- Clocking: one clock. Reset is synchronous and active-high.
- Reset values: rgb_out=0, bright_out=0, all pipeline valid/active bits 0, blink counter and phase 0.
- Stage 0 (combinational):
  - x_pos = hcount - X_OFFSET, 10-bit wrap; y_pos = vcount.
  - in_area = bright_in & (x_pos < COLS*GLYPH_W) & (y_pos < ROWS*GLYPH_H).
  - col = x_pos/GLYPH_W, gx = x_pos%GLYPH_W, row = y_pos/GLYPH_H, gy = y_pos%GLYPH_H. Use shifts/masks only; no dividers.
  - text_addr = row*COLS + col when in_area, else 0.
- Edge 1: capture P1 = {bright_in, in_area, gx, gy, col, row}. rom_addr = {text_data, P1.gy}.
- Edge 2: capture P2 = {P1.bright, P1.in_area, P1.gx, cursor_hit}.
- Edge 3, rgb_out:
  - not P2.bright -> 0
  - P2.bright and not P2.in_area -> BORDER_RGB
  - otherwise rom_data[GLYPH_W-1-P2.gx] ? fg_rgb : bg_rgb
- Latency: exactly 3 clocks from hcount/vcount/bright_in to rgb_out/bright_out. Throughput 1 pixel/clock; no stalls.
- fg_rgb/bg_rgb are sampled at edge 3 (no alignment).
- x_pos wrap: hcount < X_OFFSET produces a large x_pos, so in_area=0.
- Last cell (col=COLS-1, row=ROWS-1) addresses COLS*ROWS-1; no out-of-range address is ever driven.
- Reset mid-line: pipeline flushes. First valid rgb_out comes 3 cycles after reset deasserts.
- Elaboration error if GLYPH_W or GLYPH_H is not a power of two, or COLS*GLYPH_W > 1024.

Optional Feature:
- Macro: GLYPH_TEXT_CURSOR_EN.
- Defined:
  - Cursor ports exist.
  - Start-of-frame = sampled hcount==0 && vcount==0.
  - A frame counter 0..BLINK_FRAMES-1 toggles blink_phase on wrap.
  - cursor_hit = (P1.col==cursor_col && P1.row==cursor_row && blink_phase).
  - When cursor_hit, the glyph bit is inverted (fg/bg swap) for the whole cell.
- Undefined: no cursor ports, no counter, cursor_hit tied 0.

Decomposition:
- Package glyph_pkg: rgb_t (24-bit), X_OFFSET default, BORDER_RGB default, clog2-derived width constants.
- Sub-module glyph_pipe_delay (parametrised width/depth shift register with synchronous reset) for bright/in_area/gx alignment.

Test Plan:
- Reset, then hcount=158, vcount=0, bright_in=1, text buffer[0]=8'h41, ROM row 0 of 'A'=8'h18 -> text_addr=0, rom_addr={8'h41,3'd0}, rgb_out=bg_rgb for gx=0..2, fg_rgb for gx=3,4, valid exactly 3 cycles later.
- hcount=158+639, vcount=479 -> text_addr=4799; hcount=158+640 with bright_in=1 -> rgb_out=BORDER_RGB.
- bright_in=0 for 5 cycles -> rgb_out=0 and bright_out=0 for the 5 cycles that follow the 3-cycle latency.
- reset asserted mid-line for 1 cycle -> rgb_out=0, bright_out=0 next cycle; valid output resumes 3 cycles after release.
- GLYPH_W=16, GLYPH_H=16, COLS=40, ROWS=30: hcount=158+17, vcount=33 -> text_addr=2*40+1=81, rom_addr row=1, bit index 14 selected.
- GLYPH_TEXT_CURSOR_EN, BLINK_FRAMES=2, cursor=(1,0), glyph all 0 -> cell pixels show fg_rgb for frames 2-3 and bg_rgb for frames 0-1, repeating.
